// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: widths, NOP encoding,
// fetch FSM states, IF/ID register layout and small arithmetic helpers.
package fetch_stage_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;
    localparam logic [CNT_W-1:0]   CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Folds to a simple mask when span is a constant power of two.
    function automatic logic [XLEN-1:0] wrap_addr(input logic [XLEN-1:0] addr,
                                                  input logic [XLEN-1:0] span);
        return addr % span;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush wins over stall, stall holds, otherwise
// captures the fetched word.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output if_id_t             q_o,
    output logic               load_o
);

    if_id_t q;

    always_comb begin
        load_o = en_i && !flush_i && !stall_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.pc    <= '0;
            q.instr <= NOP;
            q.valid <= 1'b0;
        end else if (en_i) begin
            if (flush_i) begin
                q.pc    <= '0;
                q.instr <= NOP;
                q.valid <= 1'b0;
            end else if (!stall_i) begin
                q.pc    <= pc_i;
                q.instr <= instr_i;
                q.valid <= 1'b1;
            end
        end
    end

    assign q_o = q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing with branch redirect and stall,
// IF/ID register, and stall/flush/fetch event counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | fetch stopped; PC, IF/ID and counters hold
// ST_RUN  | fetching; PC advances/redirects, IF/ID loads, events count
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [XLEN-1:0]    branch_target_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [XLEN-1:0]    imem_addr_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    if_id_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o,
    output logic [31:0]        fetch_cnt_o
);

    localparam logic [XLEN-1:0] SPAN = 32'(IMEM_BYTES);

    fetch_state_t    state, state_nxt;
    logic            run_en;
    logic            if_id_load;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [31:0]     fetch_cnt;
    if_id_t          if_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping start_i in RUN freezes that same cycle, not just the next one.
    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    run_en = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (run_en) begin
            if (branch_taken_i) begin
                pc_nxt = wrap_addr({branch_target_i[XLEN-1:2], 2'b00}, SPAN);
            end else if (!stall_i) begin
                pc_nxt = wrap_addr(pc + 32'd4, SPAN);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (run_en),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .pc_i    (pc),
        .instr_i (imem_data_i),
        .q_o     (if_id),
        .load_o  (if_id_load)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            fetch_cnt <= '0;
        end else if (run_en) begin
            if (stall_i) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_i) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (if_id_load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign pc_o          = pc;
    assign imem_addr_o   = pc;
    assign if_id_pc_o    = if_id.pc;
    assign if_id_instr_o = if_id.instr;
    assign if_id_valid_o = if_id.valid;
    assign stall_cnt_o   = stall_cnt;
    assign flush_cnt_o   = flush_cnt;
    assign fetch_cnt_o   = fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded directed bench for fetch_stage: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after each edge.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] imem_data_i;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic [31:0] fetch_cnt_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic [15:0] sc;
        logic [15:0] fl;
        logic [31:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_data_i     (imem_data_i),
        .imem_addr_o     (imem_addr_o),
        .pc_o            (pc_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    // Instruction memory model: each word reads back its own address.
    assign imem_data_i = imem_addr_o;

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i or posedge rst_i);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_o",          pc_o,          e.pc);
                chk("imem_addr_o",   imem_addr_o,   e.pc);
                chk("if_id_pc_o",    if_id_pc_o,    e.ipc);
                chk("if_id_instr_o", if_id_instr_o, e.ins);
                chk("if_id_valid_o", {31'b0, if_id_valid_o}, {31'b0, e.v});
                chk("stall_cnt_o",   {16'b0, stall_cnt_o},   {16'b0, e.sc});
                chk("flush_cnt_o",   {16'b0, flush_cnt_o},   {16'b0, e.fl});
                chk("fetch_cnt_o",   fetch_cnt_o,   e.fc);
            end
        end
    end

    task automatic step(input logic rst, input logic start, input logic stall,
                        input logic flush, input logic br, input logic [31:0] tgt,
                        input logic [31:0] pc, input logic [31:0] ipc,
                        input logic v, input logic [15:0] sc, input logic [15:0] fl,
                        input logic [31:0] fc);
        exp_t e;
        @(negedge clk_i);
        rst_i = rst;
        start_i = start;
        stall_i = stall;
        flush_i = flush;
        branch_taken_i = br;
        branch_target_i = tgt;
        e.pc = pc; e.ipc = ipc; e.ins = ipc; e.v = v;
        e.sc = sc; e.fl = fl; e.fc = fc;
        sb_q.push_back(e);
    endtask

    // Reset asserted at the falling edge, half a period before the next clock.
    task automatic async_reset();
        exp_t e;
        @(negedge clk_i);
        e.pc = 32'h0; e.ipc = 32'h0; e.ins = 32'h0; e.v = 1'b0;
        e.sc = 16'h0; e.fl = 16'h0; e.fc = 32'h0;
        sb_q.push_back(e);
        rst_i = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        //    rst st  sl  fl  br  tgt            pc         ipc        v  sc  fl  fc
        step(1, 0, 0, 0, 0, 32'h0,         32'h000,   32'h000,   0, 0,  0,  0);
        step(0, 1, 0, 0, 0, 32'h0,         32'h000,   32'h000,   0, 0,  0,  0);
        step(0, 1, 0, 0, 0, 32'h0,         32'h004,   32'h000,   1, 0,  0,  1);
        step(0, 1, 0, 0, 0, 32'h0,         32'h008,   32'h004,   1, 0,  0,  2);
        step(0, 1, 0, 0, 0, 32'h0,         32'h00C,   32'h008,   1, 0,  0,  3);
        step(0, 1, 0, 0, 0, 32'h0,         32'h010,   32'h00C,   1, 0,  0,  4);
        // branch back to 8, then two stall cycles there
        step(0, 1, 0, 0, 1, 32'h8,         32'h008,   32'h010,   1, 0,  0,  5);
        step(0, 1, 1, 0, 0, 32'h0,         32'h008,   32'h010,   1, 1,  0,  5);
        step(0, 1, 1, 0, 0, 32'h0,         32'h008,   32'h010,   1, 2,  0,  5);
        step(0, 1, 0, 0, 0, 32'h0,         32'h00C,   32'h008,   1, 2,  0,  6);
        // branch + flush + stall, misaligned target
        step(0, 1, 1, 1, 1, 32'h41,        32'h040,   32'h000,   0, 3,  1,  6);
        step(0, 1, 0, 0, 0, 32'h0,         32'h044,   32'h040,   1, 3,  1,  7);
        // wrap at the top of the 1 KiB span
        step(0, 1, 0, 0, 1, 32'h3FC,       32'h3FC,   32'h044,   1, 3,  1,  8);
        step(0, 1, 0, 0, 0, 32'h0,         32'h000,   32'h3FC,   1, 3,  1,  9);
        step(0, 1, 0, 0, 0, 32'h0,         32'h004,   32'h000,   1, 3,  1, 10);
        step(0, 1, 0, 0, 1, 32'h1238,      32'h238,   32'h004,   1, 3,  1, 11);
        // start low: everything frozen, even with stall/flush/branch asserted
        step(0, 0, 0, 0, 0, 32'h0,         32'h238,   32'h004,   1, 3,  1, 11);
        step(0, 0, 1, 1, 1, 32'h100,       32'h238,   32'h004,   1, 3,  1, 11);
        step(0, 0, 0, 0, 0, 32'h0,         32'h238,   32'h004,   1, 3,  1, 11);
        step(0, 1, 0, 0, 0, 32'h0,         32'h238,   32'h004,   1, 3,  1, 11);
        step(0, 1, 0, 1, 0, 32'h0,         32'h23C,   32'h000,   0, 3,  2, 11);
        step(0, 1, 0, 0, 0, 32'h0,         32'h240,   32'h23C,   1, 3,  2, 12);
        // asynchronous reset mid-run, then restart
        async_reset();
        step(1, 1, 0, 0, 0, 32'h0,         32'h000,   32'h000,   0, 0,  0,  0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h000,   32'h000,   0, 0,  0,  0);
        step(0, 1, 0, 0, 0, 32'h0,         32'h000,   32'h000,   0, 0,  0,  0);
        step(0, 1, 0, 0, 0, 32'h0,         32'h004,   32'h000,   1, 0,  0,  1);
        step(0, 1, 0, 0, 0, 32'h0,         32'h008,   32'h004,   1, 0,  0,  2);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, PC value loaded at reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 1024, instruction-memory span; PC wraps modulo this value.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1, run enable; 0 holds the fetch stage idle.
REQ-006 SHALL have port stall_i, input, 1, hazard-unit stall; holds PC and IF/ID.
REQ-007 SHALL have port flush_i, input, 1, hazard-unit IF/ID flush.
REQ-008 SHALL have port branch_taken_i, input, 1, redirect PC to branch_target_i.
REQ-009 SHALL have port branch_target_i, input, 32, redirect address.
REQ-010 SHALL have port imem_data_i, input, 32, combinational instruction-memory read data.
REQ-011 SHALL have port imem_addr_o, output, 32, byte address to instruction memory (equals pc_o).
REQ-012 SHALL have port pc_o, output, 32, current fetch PC.
REQ-013 SHALL have port if_id_pc_o, output, 32, PC of instruction held in IF/ID.
REQ-014 SHALL have port if_id_instr_o, output, 32, instruction held in IF/ID.
REQ-015 SHALL have port if_id_valid_o, output, 1, IF/ID holds a real instruction.
REQ-016 SHALL have ports stall_cnt_o and flush_cnt_o, output, 16 each, saturating event counters.
REQ-017 SHALL have port fetch_cnt_o, output, 32, instructions accepted into IF/ID.

Function
REQ-018 SHALL implement FSM IDLE/RUN: IDLE->RUN on start_i=1; RUN->IDLE on start_i=0; in IDLE, PC and IF/ID hold and counters do not count.
REQ-019 SHALL, in RUN, update PC each cycle with priority branch_taken_i > stall_i > sequential (PC+4).
REQ-020 SHALL compute sequential and redirect PC as (value) mod IMEM_BYTES; branch_target_i low two bits forced to 0.
REQ-021 SHALL, in RUN with flush_i=1, load IF/ID with instr 32'h0, pc 0, valid 0, regardless of stall_i.
REQ-022 SHALL, in RUN with stall_i=1 and flush_i=0, hold IF/ID unchanged.
REQ-023 SHALL otherwise, in RUN, load IF/ID with imem_data_i, pc_o, valid 1 (one-cycle fetch latency).
REQ-024 SHALL increment stall_cnt_o on each RUN cycle with stall_i=1 and flush_cnt_o on each RUN cycle with flush_i=1, saturating at 16'hFFFF.
REQ-025 SHALL increment fetch_cnt_o (wrapping) on each IF/ID load of REQ-023.
REQ-026 SHALL, in IDLE, drive if_id_valid_o unchanged from last RUN value.

Reset
REQ-027 SHALL on rst_i=1 asynchronously set: FSM IDLE, pc_o=RESET_PC, IF/ID instr/pc 0, if_id_valid_o 0, all counters 0.
REQ-028 SHALL, on reset mid-RUN, discard in-flight fetch; first fetch after release requires start_i=1 sampled on a rising edge.

Structure
REQ-029 SHALL take FSM state encoding, NOP constant 32'h0 and instruction width from the shared CPU package.
REQ-030 SHALL contain exactly one sub-module, if_id_reg, holding the IF/ID pipeline register with stall/flush controls.

Verification
REQ-031 Reset, start_i=1, imem returns word=addr, 4 cycles -> pc_o 0,4,8,12,16; if_id_instr_o lags pc_o by one cycle; fetch_cnt_o=4.
REQ-032 stall_i=1 for 2 cycles at pc_o=8 -> pc_o and IF/ID frozen 2 cycles, stall_cnt_o=2, then resume at 12.
REQ-033 branch_taken_i=1, target 32'h40, flush_i=1 with stall_i=1 -> next pc_o=32'h40, if_id_valid_o=0, flush_cnt_o=1, stall_cnt_o=1.
REQ-034 IMEM_BYTES=1024, pc_o=1020, no stall -> next pc_o=0.
REQ-035 Assert rst_i asynchronously mid-RUN between clock edges -> outputs reset immediately; FSM IDLE until start_i sampled high.
REQ-036 start_i=0 for 3 cycles in RUN -> pc_o, IF/ID and all counters unchanged throughout.
